subtractor_32bit_with_carry: RTL and testbench
==============================================

Name: subtractor_32bit_with_carry

Overview:
- Registered unsigned subtractor with borrow chain-in/chain-out; computes A - B - borrow_in.
- Sits in the ALU datapath as the subtract unit; borrow_in/borrow_out allow cascading for multi-word subtraction.
- Combinational ripple-borrow core feeding an output register.
- Result appears one clock after the operands are applied.

Parameters:
- WIDTH, 32, operand and result width in bits. Only 32 is verified; the logic must be written generically in WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  WIDTH  minuend, unsigned.
- B  input  WIDTH  subtrahend, unsigned.
- borrow_in  input  1  incoming borrow; subtracts one extra LSB when 1.
- difference  output  WIDTH  registered result (A - B - borrow_in) mod 2^WIDTH.
- borrow_out  output  1  registered borrow from the MSB: 1 when A < B + borrow_in as unsigned integers.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Combinational core: ripple-borrow chain of WIDTH one-bit full-subtractor cells.
  - Per bit i: d_i = a_i XOR b_i XOR bin_i; bout_i = (~a_i & b_i) | (~(a_i XOR b_i) & bin_i).
  - bin_0 = borrow_in; borrow_out_comb = bout_(WIDTH-1).
  - Equivalent reference model: {borrow_out, difference} = {1'b0, A} - {1'b0, B} - borrow_in, evaluated at WIDTH+1 bits, with the MSB taken as the borrow.
- Output register:
  - Each rising clk edge with rst=0: difference <= core difference; borrow_out <= core borrow.
  - Each rising clk edge with rst=1: difference <= 0; borrow_out <= 0. Reset has priority over new operands.
- Latency: exactly 1 cycle. Inputs sampled at edge N are visible on the outputs after edge N.
- Throughput: one new operation per cycle. No handshake, no valid signal, no stall.
- Reset mid-operation: the pending result is discarded and outputs read 0 after the edge.
- Outputs stay 0 every cycle rst is held. The first valid result is the one sampled at the first edge with rst=0.
- Outputs hold their value only until the next edge; they always reflect the most recent sampled inputs.
- No X propagation from the register after reset. Power-up value before the first reset edge is unspecified.
- Boundaries:
  - A=B, borrow_in=0 gives 0 with borrow 0.
  - A=0, B=0, borrow_in=1 gives all-ones with borrow 1.
  - A=0, B=all-ones, borrow_in=1 gives 0 with borrow 1 (full wrap).
- Signed overflow is not reported. Interpretation is unsigned only.

Decomposition:
- Shared ALU package: constant for default data width (32).
- One natural sub-module: full_subtractor (1-bit: a, b, bin -> d, bout), instantiated WIDTH times via generate.
- Top module holds the chain plus the output register.

Test Plan:
- Reset: hold rst=1 for one edge with any inputs -> difference=0x00000000, borrow_out=0.
- A=0x00000002, B=0x00000001, borrow_in=1 -> after one edge: difference=0x00000000, borrow_out=0.
- A=0x00000000, B=0x00000001, borrow_in=1 -> difference=0xFFFFFFFE, borrow_out=1.
- A=0x80000000, B=0x80000000, borrow_in=0 -> difference=0x00000000, borrow_out=0. Also A=0, B=0xFFFFFFFF, borrow_in=1 -> difference=0x00000000, borrow_out=1.
- Back-to-back random operands, one per cycle (at least 1000 vectors) -> each output matches the WIDTH+1-bit reference model exactly one cycle later; no bubbles.
- Reset asserted while random operands keep changing -> outputs 0 on the first edge with rst=1 and stay 0 while held. The first result after deassertion corresponds to the inputs at that edge.

Source files
------------

// File: rtl/subtractor_32bit_with_carry_pkg.sv
// Shared ALU definitions for the subtract unit: default datapath width and
// the packed result type carried out of the borrow chain.
package subtractor_32bit_with_carry_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  typedef struct packed {
    logic                  borrow;
    logic [DATA_WIDTH-1:0] diff;
  } sub_result_t;

endpackage : subtractor_32bit_with_carry_pkg

// File: rtl/subtractor_32bit_with_carry_full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, with the borrow out of this bit.
module subtractor_32bit_with_carry_full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  logic a_xor_b_s;

  assign a_xor_b_s = a_i ^ b_i;
  assign d_o       = a_xor_b_s ^ bin_i;
  // Borrow when a=0,b=1, or when a==b and a borrow ripples in from below.
  assign bout_o    = (~a_i & b_i) | (~a_xor_b_s & bin_i);

endmodule : subtractor_32bit_with_carry_full_subtractor

// File: rtl/subtractor_32bit_with_carry.sv
// Registered unsigned subtractor: ripple-borrow chain of one-bit cells feeding
// an output register; difference/borrow_out appear one clock after A, B, borrow_in.
module subtractor_32bit_with_carry
  import subtractor_32bit_with_carry_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             borrow_in,
  output logic [WIDTH-1:0] difference,
  output logic             borrow_out
);

  logic [WIDTH:0]   borrow_chain_s;
  logic [WIDTH-1:0] diff_comb_s;
  logic [WIDTH-1:0] diff_d;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_d;
  logic             borrow_q;

  assign borrow_chain_s[0] = borrow_in;

  for (genvar i = 0; i < WIDTH; i++) begin : gen_cell
    subtractor_32bit_with_carry_full_subtractor u_cell (
      .a_i    (A[i]),
      .b_i    (B[i]),
      .bin_i  (borrow_chain_s[i]),
      .d_o    (diff_comb_s[i]),
      .bout_o (borrow_chain_s[i+1])
    );
  end

  always_comb begin
    diff_d   = diff_comb_s;
    borrow_d = borrow_chain_s[WIDTH];
  end

  // Reset wins over new operands so a pending result is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign difference = diff_q;
  assign borrow_out = borrow_q;

endmodule : subtractor_32bit_with_carry

// File: tb/tb_subtractor_32bit_with_carry.sv
// Self-checking bench: directed vector table, reset sequences and back-to-back
// random operands, all checked through an expected-result queue.
module tb_subtractor_32bit_with_carry;

  localparam int W = 32;

  typedef struct {
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] exp_d;
    logic         exp_b;
  } vec_t;

  typedef struct {
    logic [W-1:0] d;
    logic         b;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         borrow_in = 1'b0;
  logic [W-1:0] difference;
  logic         borrow_out;

  int checks = 0;
  int failures = 0;
  exp_t sb_q[$];
  vec_t tbl[12];

  subtractor_32bit_with_carry #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .A          (A),
    .B          (B),
    .borrow_in  (borrow_in),
    .difference (difference),
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;

  function automatic exp_t ref_model(input logic r, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic bin);
    logic [W:0] full;
    exp_t e;
    full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    e.d = r ? '0 : full[W-1:0];
    e.b = r ? 1'b0 : full[W];
    return e;
  endfunction

  // Drive one operation, push its expected result, then compare after the edge.
  task automatic step(input logic r, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic bin, input exp_t e, input string name);
    exp_t got;
    @(negedge clk);
    rst = r;
    A = a;
    B = b;
    borrow_in = bin;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      got = sb_q.pop_front();
      if (difference !== got.d) begin
        failures++;
        $display("FAIL %s diff: got %08h expected %08h (A=%08h B=%08h bin=%0b rst=%0b)",
                 name, difference, got.d, a, b, bin, r);
      end
      checks++;
      if (borrow_out !== got.b) begin
        failures++;
        $display("FAIL %s borrow: got %0b expected %0b (A=%08h B=%08h bin=%0b rst=%0b)",
                 name, borrow_out, got.b, a, b, bin, r);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rbin;

    tbl[0]  = '{1'b1, 32'hDEADBEEF, 32'h12345678, 1'b1, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b0, 32'h00000002, 32'h00000001, 1'b1, 32'h00000000, 1'b0};
    tbl[2]  = '{1'b0, 32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFE, 1'b1};
    tbl[3]  = '{1'b0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b0};
    tbl[4]  = '{1'b0, 32'h00000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b1};
    tbl[5]  = '{1'b0, 32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1};
    tbl[6]  = '{1'b0, 32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 1'b0};
    tbl[7]  = '{1'b0, 32'h0000000A, 32'h00000003, 1'b0, 32'h00000007, 1'b0};
    tbl[8]  = '{1'b0, 32'h00000003, 32'h0000000A, 1'b0, 32'hFFFFFFF9, 1'b1};
    tbl[9]  = '{1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'hFFFFFFFE, 1'b0};
    tbl[10] = '{1'b0, 32'h00000001, 32'h00000000, 1'b1, 32'h00000000, 1'b0};
    tbl[11] = '{1'b0, 32'h00010000, 32'h00000001, 1'b0, 32'h0000FFFF, 1'b0};

    for (int i = 0; i < 12; i++) begin
      e.d = tbl[i].exp_d;
      e.b = tbl[i].exp_b;
      step(tbl[i].rst, tbl[i].a, tbl[i].b, tbl[i].bin, e, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 1200; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      rbin = 1'($urandom_range(1, 0));
      if (i % 7 == 3) rb = ra;
      step(1'b0, ra, rb, rbin, ref_model(1'b0, ra, rb, rbin), "rand");
    end

    // Reset held while operands keep changing, then first result after release.
    for (int i = 0; i < 5; i++) begin
      ra = $urandom;
      rb = $urandom | 32'h00000001;
      step(1'b1, ra, rb, 1'b1, ref_model(1'b1, ra, rb, 1'b1), "rst_hold");
    end
    ra = 32'h00000000;
    rb = 32'h00000005;
    e.d = 32'hFFFFFFFB;
    e.b = 1'b1;
    step(1'b0, ra, rb, 1'b0, e, "rst_release");
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      rbin = 1'($urandom_range(1, 0));
      step(1'b0, ra, rb, rbin, ref_model(1'b0, ra, rb, rbin), "post_rst");
    end

    // Mid-stream reset pulse discards the pending result.
    e.d = 32'h00000000;
    e.b = 1'b0;
    step(1'b1, 32'h00000000, 32'h00000001, 1'b1, e, "rst_pulse");
    e.d = 32'h00000001;
    e.b = 1'b0;
    step(1'b0, 32'h00000003, 32'h00000001, 1'b1, e, "after_pulse");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_subtractor_32bit_with_carry
